// File: rtl/spi_shift_engine.sv
// SPI mode-0 single-word shift engine with registered chip-select steering (chip1_sel).
// Optional SPI_LSB_FIRST_EN adds tx_lsb_first for LSB-first transfers.
module spi_shift_engine #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_chip1,
  input  logic              tx_valid,
`ifdef SPI_LSB_FIRST_EN
  input  logic              tx_lsb_first,
`endif
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              pico,
  input  logic              poci,
  output logic              cs_b,
  output logic              chip1_sel
);

  localparam int unsigned BIT_W  = $clog2(DATA_W + 1);
  localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);
  localparam int unsigned CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned CS_W   = $clog2(CS_MAX + 1);

  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CS_W-1:0]  SETUP_LAST = CS_W'(CS_SETUP - 1);
  localparam logic [CS_W-1:0]  HOLD_LAST  = CS_W'(CS_HOLD - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_next;
  logic [DATA_W-1:0] rx_next;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [CS_W-1:0]   cs_cnt;
  logic              lsb_q;
  logic              lsb_in;
  logic              first_bit;
  logic              pico_next;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = tx_lsb_first;
`else
  assign lsb_in = 1'b0;
  assign lsb_q  = 1'b0;
`endif

  always_comb begin
    first_bit = lsb_in ? tx_data[0] : tx_data[DATA_W-1];
    tx_next   = lsb_q ? (tx_shift >> 1) : (tx_shift << 1);
    pico_next = lsb_q ? tx_next[0] : tx_next[DATA_W-1];
    rx_next   = lsb_q ? (rx_shift >> 1) : (rx_shift << 1);
    // LSB-first fills from the top so the first received bit ends in bit 0
    if (lsb_q) rx_next[DATA_W-1] = poci;
    else       rx_next[0]        = poci;
  end

`ifdef SPI_LSB_FIRST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    lsb_q <= 1'b0;
    else if (state == IDLE && tx_valid && tx_ready) lsb_q <= tx_lsb_first;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cs_b      <= 1'b1;
      sclk      <= 1'b0;
      pico      <= 1'b0;
      chip1_sel <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      tx_ready  <= 1'b1;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      cs_cnt    <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            state     <= SETUP;
            cs_b      <= 1'b0;
            pico      <= first_bit;
            tx_shift  <= tx_data;
            rx_shift  <= '0;
            chip1_sel <= tx_chip1;
            busy      <= 1'b1;
            tx_ready  <= 1'b0;
            cs_cnt    <= '0;
          end
        end
        SETUP: begin
          if (cs_cnt == SETUP_LAST) begin
            state   <= SHIFT;
            sclk    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            cs_cnt <= cs_cnt + CS_W'(1);
          end
        end
        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else if (sclk) begin
            // last high cycle: capture poci, drop sclk, advance pico unless the word is done
            rx_shift <= rx_next;
            sclk     <= 1'b0;
            div_cnt  <= '0;
            if (bit_cnt != BIT_LAST) begin
              tx_shift <= tx_next;
              pico     <= pico_next;
            end
          end else if (bit_cnt == BIT_LAST) begin
            state  <= HOLD;
            cs_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            sclk    <= 1'b1;
            div_cnt <= '0;
          end
        end
        HOLD: begin
          if (cs_cnt == HOLD_LAST) begin
            state    <= IDLE;
            cs_b     <= 1'b1;
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
          end else begin
            cs_cnt <= cs_cnt + CS_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine (DATA_W=8, CLK_DIV=2, CS_SETUP=2, CS_HOLD=2).
// Define SPI_LSB_FIRST_EN to also exercise the LSB-first transfer.
module tb_spi_shift_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_chip1 = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sclk;
  logic       pico;
  logic       poci = 1'b0;
  logic       cs_b;
  logic       chip1_sel;
`ifdef SPI_LSB_FIRST_EN
  logic       tx_lsb_first = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  spi_shift_engine #(.DATA_W(8), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_chip1  (tx_chip1),
    .tx_valid  (tx_valid),
`ifdef SPI_LSB_FIRST_EN
    .tx_lsb_first(tx_lsb_first),
`endif
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .sclk      (sclk),
    .pico      (pico),
    .poci      (poci),
    .cs_b      (cs_b),
    .chip1_sel (chip1_sel)
  );

  always #5 clk = ~clk;

  // Bus observer: cycle numbering is relative to the accept edge (cycle 1 follows it)
  int         cyc = 0;
  int         acc = 0;
  logic [7:0] poci_word = '0;
  logic       prev_sclk = 1'b0;
  logic       prev_cs = 1'b1;
  int cs_first, cs_last, cs_low_n, cs_hi_run, gap, cs_fall_n;
  int pulses, hi_run, lo_run, hi_min, hi_max, lo_min, lo_max, poci_idx;
  int rv_n, rv_total, rv_rel, sel_changes;
  logic [7:0] pico_cap;
  logic sel_at_fall, sel_at_rv;

  initial begin
    cs_first = 0; cs_last = 0; cs_low_n = 0; cs_hi_run = 0; gap = 0; cs_fall_n = 0;
    pulses = 0; hi_run = 0; lo_run = 0; hi_min = 99; hi_max = 0; lo_min = 99; lo_max = 0;
    poci_idx = 0; rv_n = 0; rv_total = 0; rv_rel = 0; sel_changes = 0;
    pico_cap = '0; sel_at_fall = 1'b0; sel_at_rv = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!cs_b && prev_cs) begin
      cs_fall_n++; gap = cs_hi_run; cs_hi_run = 0;
      cs_first = cyc - acc + 1; cs_low_n = 0;
      pulses = 0; hi_run = 0; lo_run = 0; hi_min = 99; hi_max = 0; lo_min = 99; lo_max = 0;
      pico_cap = '0; poci_idx = 0; sel_at_fall = chip1_sel; sel_changes = 0; rv_n = 0;
    end
    if (cs_b) cs_hi_run++;
    else begin
      cs_low_n++; cs_last = cyc - acc + 1;
      if (chip1_sel !== sel_at_fall) sel_changes++;
    end
    if (sclk) begin
      if (!prev_sclk) begin
        pico_cap = {pico_cap[6:0], pico};
        if (poci_idx < 8) poci = poci_word[7 - poci_idx];
        poci_idx++;
        if (pulses > 0) begin
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
        end
        lo_run = 0;
      end
      hi_run++;
    end else begin
      if (prev_sclk) begin
        pulses++;
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0;
      end
      if (!cs_b) lo_run++;
    end
    if (rx_valid) begin
      rv_n++; rv_total++; rv_rel = cyc - acc + 1; sel_at_rv = chip1_sel;
    end
    prev_sclk = sclk;
    prev_cs   = cs_b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_txn(input logic [7:0] d, input logic c, input logic [7:0] pw);
    @(negedge clk);
    tx_data = d; tx_chip1 = c; poci_word = pw; tx_valid = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (rx_valid) seen = 1'b1;
    end
    #2;
    check({tag, "_rx_valid_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int   rv0, cf0;
    logic found;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_b", 32'(cs_b), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_pico", 32'(pico), 32'd0);
    check("rst_chip1_sel", 32'(chip1_sel), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    @(negedge clk) rst = 1'b0;

    // A5 to chip1, poci returns 3C
    start_txn(8'hA5, 1'b1, 8'h3C);
    wait_rx("t1");
    check("t1_rx_data", 32'(rx_data), 32'h3C);
    check("t1_rx_valid_cycle", 32'(rv_rel), 32'd37);
    check("t1_cs_first", 32'(cs_first), 32'd1);
    check("t1_cs_last", 32'(cs_last), 32'd36);
    check("t1_cs_low_cycles", 32'(cs_low_n), 32'd36);
    check("t1_pico_bits", 32'(pico_cap), 32'hA5);
    check("t1_chip1_sel", 32'(chip1_sel), 32'd1);
    check("t1_pulses", 32'(pulses), 32'd8);
    check("t1_rx_valid_count", 32'(rv_n), 32'd1);

    // 0F to chip2: steering and sclk shape
    start_txn(8'h0F, 1'b0, 8'hF0);
    wait_rx("t2");
    check("t2_sel_at_cs_fall", 32'(sel_at_fall), 32'd0);
    check("t2_sel_changes", 32'(sel_changes), 32'd0);
    check("t2_sel_at_cs_rise", 32'(sel_at_rv), 32'd0);
    check("t2_pulses", 32'(pulses), 32'd8);
    check("t2_hi_min", 32'(hi_min), 32'd2);
    check("t2_hi_max", 32'(hi_max), 32'd2);
    check("t2_lo_min", 32'(lo_min), 32'd2);
    check("t2_lo_max", 32'(lo_max), 32'd2);
    check("t2_pico_bits", 32'(pico_cap), 32'h0F);
    check("t2_rx_data", 32'(rx_data), 32'hF0);

    // back-to-back with tx_valid held
    @(negedge clk);
    tx_data = 8'h81; tx_chip1 = 1'b1; poci_word = 8'hC3; tx_valid = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    tx_data = 8'h7E;
    wait_rx("t3a");
    check("t3a_rx_data", 32'(rx_data), 32'hC3);
    check("t3a_pico_bits", 32'(pico_cap), 32'h81);
    check("t3a_rx_valid_cycle", 32'(rv_rel), 32'd37);
    @(posedge clk);
    #1 acc = cyc;
    tx_valid = 1'b0;
    wait_rx("t3b");
    check("t3_cs_high_gap", 32'(gap), 32'd1);
    check("t3b_cs_first", 32'(cs_first), 32'd1);
    check("t3b_rx_data", 32'(rx_data), 32'hC3);
    check("t3b_pico_bits", 32'(pico_cap), 32'h7E);
    check("t3b_rx_valid_cycle", 32'(rv_rel), 32'd37);

    // tx_valid pulsed mid-shift is ignored
    start_txn(8'h3C, 1'b1, 8'h5A);
    repeat (10) @(negedge clk);
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(posedge clk);
    #1;
    check("t4_tx_ready_in_shift", 32'(tx_ready), 32'd0);
    check("t4_busy_in_shift", 32'(busy), 32'd1);
    @(negedge clk) tx_valid = 1'b0;
    wait_rx("t4");
    check("t4_rx_valid_count", 32'(rv_n), 32'd1);
    check("t4_pico_bits", 32'(pico_cap), 32'h3C);
    check("t4_rx_data", 32'(rx_data), 32'h5A);
    cf0 = cs_fall_n;
    repeat (40) @(negedge clk);
    #2;
    check("t4_no_extra_txn", 32'(cs_fall_n), 32'(cf0));
    check("t4_idle_busy", 32'(busy), 32'd0);

    // async reset after 3 sclk pulses
    start_txn(8'h9A, 1'b1, 8'hFF);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #2;
      if (pulses >= 3) found = 1'b1;
    end
    check("t5_reached_3_pulses", 32'(found), 32'd1);
    rv0 = rv_total;
    rst = 1'b1;
    #1;
    check("t5_rst_cs_b", 32'(cs_b), 32'd1);
    check("t5_rst_sclk", 32'(sclk), 32'd0);
    check("t5_rst_pico", 32'(pico), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_tx_ready", 32'(tx_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #2;
    check("t5_no_rx_valid", 32'(rv_total), 32'(rv0));
    check("t5_rx_data_cleared", 32'(rx_data), 32'h0);
    start_txn(8'h55, 1'b0, 8'hAA);
    wait_rx("t5");
    check("t5_rx_data", 32'(rx_data), 32'hAA);
    check("t5_pico_bits", 32'(pico_cap), 32'h55);
    check("t5_rx_valid_cycle", 32'(rv_rel), 32'd37);
    check("t5_chip1_sel", 32'(chip1_sel), 32'd0);

`ifdef SPI_LSB_FIRST_EN
    // LSB-first: first bit on the wire is tx_data[0], first received lands in rx_data[0]
    tx_lsb_first = 1'b1;
    start_txn(8'h01, 1'b1, 8'h80);
    wait_rx("t6");
    check("t6_pico_bits", 32'(pico_cap), 32'h80);
    check("t6_rx_data", 32'(rx_data), 32'h01);
    tx_lsb_first = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
